// File: rtl/pf_lanectrl_pause_arbiter.sv
// Pause arbiter for the lane-controller HS_IO_CLK_PAUSE input.
// Several requesters share one pause line. Each access follows the same
// sequence: raise pause, wait for setup, grant one requester, wait for the
// grant to be released (or forced off), wait for hold, drop pause, then
// keep pause low for a minimum gap. Winners are picked round-robin. A
// requester whose grant is forced off is locked out until it drops REQ.
module pf_lanectrl_pause_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PRE_CYC  = 4,
    parameter int POST_CYC = 4,
    parameter int GAP_CYC  = 2,
    parameter int MAX_HOLD = 64
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_REQ-1:0] REQ,
    output logic [NUM_REQ-1:0] GNT,
    output logic               HS_IO_CLK_PAUSE,
    output logic               BUSY,
    output logic               TIMEOUT
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Counter reload values; all phases share one 8-bit down-counter.
    localparam logic [7:0] PRE_LD  = 8'(PRE_CYC - 1);
    localparam logic [7:0] POST_LD = 8'(POST_CYC - 1);
    localparam logic [7:0] HOLD_LD = 8'(MAX_HOLD - 1);
    localparam logic [7:0] GAP_LD  = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_GRANT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             state_q,   state_d;
    logic [7:0]         cnt_q,     cnt_d;
    logic [IDX_W-1:0]   winner_q,  winner_d;
    logic [IDX_W-1:0]   ptr_q,     ptr_d;
    logic [NUM_REQ-1:0] lockout_q, lockout_d;
    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic               pause_q,   pause_d;
    logic               busy_q,    busy_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] req_eff_s;

    // First set bit at or above ptr, wrapping around past the top index.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic             found;
        logic [IDX_W-1:0] pick;
        int               idx;
        found = 1'b0;
        pick  = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Round-robin pointer just past the given winner, modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
        if (int'(w) >= NUM_REQ - 1) begin
            return {IDX_W{1'b0}};
        end else begin
            return w + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // One-hot vector with only the given index set.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] w);
        logic [NUM_REQ-1:0] v;
        v    = {NUM_REQ{1'b0}};
        v[w] = 1'b1;
        return v;
    endfunction

    assign req_eff_s = REQ & ~lockout_q;

    // Sequencer next state: pause/grant phases, counter, pointer and lockout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        winner_d  = winner_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        pause_d   = pause_q;
        timeout_d = 1'b0;
        // A requester leaves lockout in any cycle its REQ is low.
        lockout_d = lockout_q & REQ;

        case (state_q)
            ST_IDLE: begin
                gnt_d = {NUM_REQ{1'b0}};
                if (|req_eff_s) begin
                    winner_d = rr_pick(req_eff_s, ptr_q);
                    pause_d  = 1'b1;
                    cnt_d    = PRE_LD;
                    state_d  = ST_SETUP;
                end else begin
                    pause_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                // Withdrawn requests are ignored here; the grant is issued anyway.
                if (cnt_q == 8'd0) begin
                    gnt_d   = onehot(winner_q);
                    cnt_d   = HOLD_LD;
                    ptr_d   = next_ptr(winner_q);
                    state_d = ST_GRANT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GRANT: begin
                // Release by the requester takes priority over the forced release.
                if (!REQ[winner_q]) begin
                    gnt_d   = {NUM_REQ{1'b0}};
                    cnt_d   = POST_LD;
                    state_d = ST_HOLD;
                end else if (cnt_q == 8'd0) begin
                    gnt_d               = {NUM_REQ{1'b0}};
                    timeout_d           = 1'b1;
                    lockout_d[winner_q] = 1'b1;
                    cnt_d               = POST_LD;
                    state_d             = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    pause_d = 1'b0;
                    if (GAP_CYC == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = GAP_LD;
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = {NUM_REQ{1'b0}};
                pause_d = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset clears grant and pause at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            winner_q  <= {IDX_W{1'b0}};
            ptr_q     <= {IDX_W{1'b0}};
            lockout_q <= {NUM_REQ{1'b0}};
            gnt_q     <= {NUM_REQ{1'b0}};
            pause_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            winner_q  <= winner_d;
            ptr_q     <= ptr_d;
            lockout_q <= lockout_d;
            gnt_q     <= gnt_d;
            pause_q   <= pause_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign GNT             = gnt_q;
    assign HS_IO_CLK_PAUSE = pause_q;
    assign BUSY            = busy_q;
    assign TIMEOUT         = timeout_q;

endmodule

// File: tb/tb_pf_lanectrl_pause_arbiter.sv
// Bench for pf_lanectrl_pause_arbiter: one instance with default timing and
// one with minimum timing. Stimulus pushes expected output changes
// (cycle, {GNT, pause, BUSY, TIMEOUT}) into per-instance queues; a monitor
// pops and compares every time an instance's outputs change.
module tb_pf_lanectrl_pause_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic       pause_a, pause_b, busy_a, busy_b, tmo_a, tmo_b;
    logic [6:0] obs_a, obs_b;
    logic [6:0] prev_a, prev_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [6:0] val;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];

    pf_lanectrl_pause_arbiter #(
        .NUM_REQ(4), .PRE_CYC(4), .POST_CYC(4), .GAP_CYC(2), .MAX_HOLD(64)
    ) dut_a (
        .CLK(clk), .RESET_N(rst_n), .REQ(req_a), .GNT(gnt_a),
        .HS_IO_CLK_PAUSE(pause_a), .BUSY(busy_a), .TIMEOUT(tmo_a)
    );

    pf_lanectrl_pause_arbiter #(
        .NUM_REQ(4), .PRE_CYC(1), .POST_CYC(1), .GAP_CYC(0), .MAX_HOLD(1)
    ) dut_b (
        .CLK(clk), .RESET_N(rst_n), .REQ(req_b), .GNT(gnt_b),
        .HS_IO_CLK_PAUSE(pause_b), .BUSY(busy_b), .TIMEOUT(tmo_b)
    );

    assign obs_a = {gnt_a, pause_a, busy_a, tmo_a};
    assign obs_b = {gnt_b, pause_b, busy_b, tmo_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] mk(input logic [3:0] g, input logic p,
                                      input logic b, input logic t);
        return {g, p, b, t};
    endfunction

    task automatic push(input int d, input int c, input logic [6:0] v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_now(input string name, input logic [6:0] act, input logic [6:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: actual=%b expected=%b", name, act, exp_v);
        end
    endtask

    task automatic on_change(input int d, input logic [6:0] v);
        ev_t e;
        checks++;
        if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_change dut%0d: cycle=%0d value=%b expected no change",
                     d, cyc, v);
        end else begin
            if (d == 0) e = q_a.pop_front();
            else        e = q_b.pop_front();
            if (e.cyc != cyc || e.val !== v) begin
                errors++;
                $display("FAIL event dut%0d: actual cycle=%0d value=%b expected cycle=%0d value=%b",
                         d, cyc, v, e.cyc, e.val);
            end
        end
    endtask

    task automatic check_inv(input int d, input logic [6:0] v);
        checks++;
        if (v[6:3] != 4'b0000 && !v[2]) begin
            errors++;
            $display("FAIL gnt_without_pause dut%0d: cycle=%0d value=%b", d, cyc, v);
        end
        checks++;
        if (!$onehot0(v[6:3])) begin
            errors++;
            $display("FAIL gnt_onehot dut%0d: cycle=%0d gnt=%b", d, cyc, v[6:3]);
        end
    endtask

    // Monitor: sample away from the active edge, compare on every output change.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (obs_a !== prev_a) on_change(0, obs_a);
                if (obs_b !== prev_b) on_change(1, obs_b);
                check_inv(0, obs_a);
                check_inv(1, obs_b);
                prev_a = obs_a;
                prev_b = obs_b;
            end
        end
    end

    // Watchdog.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Minimum-timing instance: 1-cycle grant, timeout, back-to-back access.
    initial begin
        req_b = 4'b0000;
        push(1, 21, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(1, 22, mk(4'b0001, 1'b1, 1'b1, 1'b0));
        push(1, 23, mk(4'b0000, 1'b1, 1'b1, 1'b1));
        push(1, 24, mk(4'b0000, 1'b0, 1'b0, 1'b0));
        push(1, 25, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(1, 26, mk(4'b0010, 1'b1, 1'b1, 1'b0));
        push(1, 27, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(1, 28, mk(4'b0000, 1'b0, 1'b0, 1'b0));
        push(1, 37, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(1, 38, mk(4'b0001, 1'b1, 1'b1, 1'b0));
        push(1, 39, mk(4'b0000, 1'b1, 1'b1, 1'b1));
        push(1, 40, mk(4'b0000, 1'b0, 1'b0, 1'b0));
        at_cycle(20);
        req_b = 4'b0011;
        at_cycle(26);
        req_b = 4'b0001;   // requester 1 releases; requester 0 stays locked out
        at_cycle(35);
        req_b = 4'b0000;   // drop clears the lockout
        at_cycle(36);
        req_b = 4'b0001;
        at_cycle(39);
        req_b = 4'b0000;
    end

    // Default-timing instance: main sequence.
    initial begin
        int g;
        int order [6];
        logic [3:0] oh;
        order = '{0, 1, 3, 0, 1, 3};
        req_a = 4'b0000;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_now("reset_a", obs_a, 7'b0000000);
        check_now("reset_b", obs_b, 7'b0000000);
        prev_a = obs_a;
        prev_b = obs_b;
        mon_en = 1'b1;
        at_cycle(3);
        rst_n = 1'b1;

        // Single request from requester 0.
        push(0, 11, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 15, mk(4'b0001, 1'b1, 1'b1, 1'b0));
        push(0, 21, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 25, mk(4'b0000, 1'b0, 1'b1, 1'b0));
        push(0, 27, mk(4'b0000, 1'b0, 1'b0, 1'b0));
        at_cycle(10);
        req_a = 4'b0001;
        at_cycle(20);
        req_a = 4'b0000;

        // Reset during GRANT, then lowest active requester wins.
        push(0, 31, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 35, mk(4'b0100, 1'b1, 1'b1, 1'b0));
        push(0, 42, mk(4'b0000, 1'b0, 1'b0, 1'b0));
        push(0, 45, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 49, mk(4'b0010, 1'b1, 1'b1, 1'b0));
        push(0, 53, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 57, mk(4'b0000, 1'b0, 1'b1, 1'b0));
        push(0, 59, mk(4'b0000, 1'b0, 1'b0, 1'b0));
        at_cycle(30);
        req_a = 4'b0100;
        at_cycle(40);
        req_a = 4'b0110;
        at_cycle(42);
        rst_n = 1'b0;
        #1;
        check_now("async_reset_a", obs_a, 7'b0000000);
        at_cycle(44);
        rst_n = 1'b1;
        at_cycle(52);
        req_a = 4'b0000;

        // Idle reset pulse returns the pointer to 0.
        at_cycle(62);
        rst_n = 1'b0;
        at_cycle(64);
        rst_n = 1'b1;

        // Round robin on 1011; each holder releases with a 1-cycle drop.
        push(0, 71, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 6; k++) begin
            g  = 75 + 15 * k;
            oh = 4'b0001 << order[k];
            push(0, g,      mk(oh,      1'b1, 1'b1, 1'b0));
            push(0, g + 4,  mk(4'b0000, 1'b1, 1'b1, 1'b0));
            push(0, g + 8,  mk(4'b0000, 1'b0, 1'b1, 1'b0));
            push(0, g + 10, mk(4'b0000, 1'b0, 1'b0, 1'b0));
            if (k < 5) push(0, g + 11, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        end
        at_cycle(70);
        req_a = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            g = 75 + 15 * k;
            at_cycle(g + 3);
            if (k < 5) begin
                req_a[order[k]] = 1'b0;
                at_cycle(g + 4);
                req_a[order[k]] = 1'b1;
            end else begin
                req_a = 4'b0000;
            end
        end

        // Timeout on requester 2, lockout until it drops REQ.
        push(0, 171, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 175, mk(4'b0100, 1'b1, 1'b1, 1'b0));
        push(0, 239, mk(4'b0000, 1'b1, 1'b1, 1'b1));
        push(0, 240, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 243, mk(4'b0000, 1'b0, 1'b1, 1'b0));
        push(0, 245, mk(4'b0000, 1'b0, 1'b0, 1'b0));
        push(0, 272, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 276, mk(4'b0100, 1'b1, 1'b1, 1'b0));
        push(0, 281, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 285, mk(4'b0000, 1'b0, 1'b1, 1'b0));
        push(0, 287, mk(4'b0000, 1'b0, 1'b0, 1'b0));
        at_cycle(170);
        req_a = 4'b0100;
        at_cycle(270);
        req_a = 4'b0000;
        at_cycle(271);
        req_a = 4'b0100;
        at_cycle(280);
        req_a = 4'b0000;

        // Release in the same cycle the hold counter reaches 0: no timeout,
        // no lockout, so requester 3 is served again straight away.
        push(0, 291, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 295, mk(4'b1000, 1'b1, 1'b1, 1'b0));
        push(0, 359, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 363, mk(4'b0000, 1'b0, 1'b1, 1'b0));
        push(0, 365, mk(4'b0000, 1'b0, 1'b0, 1'b0));
        push(0, 371, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 375, mk(4'b1000, 1'b1, 1'b1, 1'b0));
        push(0, 381, mk(4'b0000, 1'b1, 1'b1, 1'b0));
        push(0, 385, mk(4'b0000, 1'b0, 1'b1, 1'b0));
        push(0, 387, mk(4'b0000, 1'b0, 1'b0, 1'b0));
        at_cycle(290);
        req_a = 4'b1000;
        at_cycle(358);
        req_a = 4'b0000;
        at_cycle(370);
        req_a = 4'b1000;
        at_cycle(380);
        req_a = 4'b0000;

        at_cycle(395);
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL pending_a: %0d expected events never seen, expected 0", q_a.size());
        end
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL pending_b: %0d expected events never seen, expected 0", q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
